keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_SCANS, default 4: number of complete row sweeps a key stays pressed.
REQ-002 Parameter RELEASE_SCANS, default 2: number of complete row sweeps of forced release after a press.
REQ-003 Parameter BOUNCE_CYCLES, default 8: clocks of contact-bounce emulation at press start (used only with BOUNCE_EN).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 init  input  1  reset, synchronous, active-high.
REQ-006 rows  input  4  row drive from the scanner; one-hot when valid.
REQ-007 key_valid  input  1  press request qualifier.
REQ-008 key  input  4  digit to press, 0-9.
REQ-009 key_ready  output  1  high only in IDLE; a request is accepted when key_valid and key_ready are both high on a clock edge.
REQ-010 cols  output  4  column response to the scanner.
REQ-011 busy  output  1  high in PRESS or RELEASE.
REQ-012 done  output  1  one-cycle pulse when RELEASE completes.
REQ-013 err  output  1  one-cycle pulse when a request with key > 9 is rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, PRESS and RELEASE, encoded in 2 bits.
REQ-015 In IDLE, an accepted request with key <= 9 SHALL latch key, clear the scan counter and move to PRESS on the next edge.
REQ-016 In IDLE, an accepted request with key > 9 SHALL pulse err the next cycle, stay in IDLE and latch nothing.
REQ-017 Scan boundary: rows registered value == 4'b1000 and current rows == 4'b0001; detection needs a 1-cycle registered copy of rows.
REQ-018 PRESS SHALL count scan boundaries and move to RELEASE on the edge where the count reaches HOLD_SCANS; counter width is clog2(max(HOLD_SCANS,RELEASE_SCANS)+1).
REQ-019 RELEASE SHALL count scan boundaries, move to IDLE on the RELEASE_SCANS-th boundary, and pulse done in the same cycle that IDLE is entered.
REQ-020 A scan boundary on the PRESS entry edge SHALL NOT be counted; only boundaries while in the state count.
REQ-021 cols SHALL be combinational from rows and the latched key, and SHALL be nonzero only in PRESS.
REQ-022 Key map in PRESS: rows 0001 -> key 1/2/3 gives cols 1000/0100/0010; rows 0010 -> 4/5/6 the same; rows 0100 -> 7/8/9 the same; rows 1000 -> key 0 gives cols 0100.
REQ-023 A rows value that does not select the latched key's row, including non-one-hot rows, SHALL give cols = 4'b0000.
REQ-024 key_valid SHALL be ignored while busy; requests are not queued.
REQ-025 If rows never sweeps, PRESS SHALL persist indefinitely; there is no timeout.

Reset
REQ-026 init high SHALL, on the next edge, force IDLE and clear the counter, the latched key, the registered rows copy, done and err.
REQ-027 After reset: cols = 0000, busy = 0, key_ready = 1, done = 0, err = 0.
REQ-028 init asserted mid-PRESS or mid-RELEASE SHALL abort with no done pulse; init takes priority over a same-cycle key_valid.

Configuration
REQ-029 Macro KEYPAD_EMULATOR_BOUNCE_EN: when defined, the first BOUNCE_CYCLES clocks of PRESS gate cols with a bounce bit that toggles every clock, starting at 1.
REQ-030 Without KEYPAD_EMULATOR_BOUNCE_EN, cols is clean from the first PRESS cycle; the bounce counter SHALL not exist.
REQ-031 Bounce SHALL NOT change the scan counting or the FSM timing.

Verification
REQ-032 Reset, then sweep rows 0001->0010->0100->1000 every 4 clocks -> cols = 0000, key_ready = 1 throughout.
REQ-033 Request key = 5 with default parameters -> cols = 0100 only while rows = 0010 for 4 sweeps, then 0000 for 2 sweeps, then one done pulse and key_ready = 1.
REQ-034 Request key = 0, then key = 9 while busy -> only key 0 is pressed (cols = 0100 at rows = 1000); the key 9 request is ignored.
REQ-035 Request key = 12 -> err pulse for 1 cycle, no busy, cols = 0000.
REQ-036 Request key = 1, assert init during the 2nd sweep -> next cycle cols = 0000, busy = 0, no done pulse.
REQ-037 With KEYPAD_EMULATOR_BOUNCE_EN, request key = 3 with rows held at 0001 -> cols alternates 0010/0000 for 8 clocks, then holds 0010.

Source files
------------

// File: rtl/keypad_emulator.sv
// ============================================================================
//  keypad_emulator
//  Emulates a 3x4 phone keypad behind a row-scanning controller: presses one
//  digit for HOLD_SCANS sweeps, then forces release for RELEASE_SCANS sweeps.
//  Optional feature macro: KEYPAD_EMULATOR_BOUNCE_EN (contact-bounce on press)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_emulator #(
  parameter int HOLD_SCANS    = 4,
  parameter int RELEASE_SCANS = 2,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       init,
  input  logic [3:0] rows,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       key_ready,
  output logic [3:0] cols,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int c_MAX_SCANS = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int c_CW        = $clog2(c_MAX_SCANS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [c_CW-1:0] w_cnt_inc;
  logic [3:0]      r_key;
  logic [3:0]      r_rows;
  logic            r_done;
  logic            r_err;
  logic            w_key_ld;
  logic            w_done_nxt;
  logic            w_err_nxt;
  logic            w_boundary;
  logic [3:0]      w_key_row;
  logic [3:0]      w_key_col;
  logic            w_gate;

  // A sweep wraps when the last row is followed directly by the first row.
  assign w_boundary = (r_rows == 4'b1000) && (rows == 4'b0001);
  assign w_cnt_inc  = r_cnt + c_CW'(1);

  always_ff @(posedge clk) begin
    if (init) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_ld    = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          if (key <= 4'd9) begin
            w_key_ld    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PRESS;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (w_boundary) begin
          if (w_cnt_inc == c_CW'(HOLD_SCANS)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RELEASE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      ST_RELEASE: begin
        if (w_boundary) begin
          if (w_cnt_inc == c_CW'(RELEASE_SCANS)) begin
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      r_cnt  <= '0;
      r_key  <= '0;
      r_rows <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_rows <= rows;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_key_ld) begin
        r_key <= key;
      end
    end
  end

  // Row that scans the latched digit and the column it answers on.
  always_comb begin
    w_key_row = 4'b0000;
    w_key_col = 4'b0000;
    case (r_key)
      4'd0: begin w_key_row = 4'b1000; w_key_col = 4'b0100; end
      4'd1: begin w_key_row = 4'b0001; w_key_col = 4'b1000; end
      4'd2: begin w_key_row = 4'b0001; w_key_col = 4'b0100; end
      4'd3: begin w_key_row = 4'b0001; w_key_col = 4'b0010; end
      4'd4: begin w_key_row = 4'b0010; w_key_col = 4'b1000; end
      4'd5: begin w_key_row = 4'b0010; w_key_col = 4'b0100; end
      4'd6: begin w_key_row = 4'b0010; w_key_col = 4'b0010; end
      4'd7: begin w_key_row = 4'b0100; w_key_col = 4'b1000; end
      4'd8: begin w_key_row = 4'b0100; w_key_col = 4'b0100; end
      4'd9: begin w_key_row = 4'b0100; w_key_col = 4'b0010; end
      default: begin w_key_row = 4'b0000; w_key_col = 4'b0000; end
    endcase
  end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int c_BW = $clog2(BOUNCE_CYCLES + 2);

  logic [c_BW-1:0] r_bcnt;

  // Counts PRESS clocks; even counts below BOUNCE_CYCLES let the contact through.
  always_ff @(posedge clk) begin
    if (init) begin
      r_bcnt <= '0;
    end else if (w_key_ld) begin
      r_bcnt <= '0;
    end else if ((r_state == ST_PRESS) && (r_bcnt < c_BW'(BOUNCE_CYCLES))) begin
      r_bcnt <= r_bcnt + c_BW'(1);
    end
  end

  assign w_gate = (r_bcnt >= c_BW'(BOUNCE_CYCLES)) || !r_bcnt[0];
`else
  assign w_gate = 1'b1;
`endif

  assign cols      = ((r_state == ST_PRESS) && w_gate && (rows == w_key_row)) ? w_key_col : 4'b0000;
  assign key_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_PRESS) || (r_state == ST_RELEASE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_keypad_emulator.sv
// ============================================================================
//  tb_keypad_emulator
//  Directed and randomized checks of keypad_emulator against a sweep-level model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keypad_emulator;

  localparam int HOLD_SCANS    = 4;
  localparam int RELEASE_SCANS = 2;
  localparam int BOUNCE_CYCLES = 8;

  logic       clk = 1'b0;
  logic       init;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key;
  logic       key_ready;
  logic [3:0] cols;
  logic       busy;
  logic       done;
  logic       err;

  keypad_emulator #(
    .HOLD_SCANS   (HOLD_SCANS),
    .RELEASE_SCANS(RELEASE_SCANS),
    .BOUNCE_CYCLES(BOUNCE_CYCLES)
  ) u_dut (
    .clk      (clk),
    .init     (init),
    .rows     (rows),
    .key_valid(key_valid),
    .key      (key),
    .key_ready(key_ready),
    .cols     (cols),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_k0_hit = 0;

  // Model: phase 0 idle, 1 holding the key, 2 forced release.
  int         m_phase;
  int         m_sweeps;
  int         m_key;
  int         m_pcyc;
  logic [3:0] m_prev_rows;
  bit         m_done;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_cols(input logic [3:0] r);
    logic [3:0] row;
    logic [3:0] col;
    if (m_phase != 1) return 4'b0000;
    if (m_key == 0) begin
      row = 4'b1000;
      col = 4'b0100;
    end else begin
      row = 4'(1 << ((m_key - 1) / 3));
      col = 4'(8 >> ((m_key - 1) % 3));
    end
    if (r != row) return 4'b0000;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    if ((m_pcyc < BOUNCE_CYCLES) && (m_pcyc % 2 == 1)) return 4'b0000;
`endif
    return col;
  endfunction

  function automatic void model_reset();
    m_phase     = 0;
    m_sweeps    = 0;
    m_key       = 0;
    m_pcyc      = 0;
    m_prev_rows = 4'b0000;
    m_done      = 1'b0;
    m_err       = 1'b0;
  endfunction

  function automatic void model_edge(input logic ini, input logic [3:0] r,
                                     input logic kv, input logic [3:0] k);
    bit wrapped;
    if (ini) begin
      model_reset();
      return;
    end
    wrapped = (m_prev_rows == 4'b1000) && (r == 4'b0001);
    m_done  = 1'b0;
    m_err   = 1'b0;
    if (m_phase == 0) begin
      if (kv) begin
        if (k <= 9) begin
          m_key    = int'(k);
          m_phase  = 1;
          m_sweeps = 0;
          m_pcyc   = 0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_phase == 1) begin
      m_pcyc++;
      if (wrapped) m_sweeps++;
      if (m_sweeps == HOLD_SCANS) begin
        m_phase  = 2;
        m_sweeps = 0;
      end
    end else begin
      if (wrapped) m_sweeps++;
      if (m_sweeps == RELEASE_SCANS) begin
        m_phase  = 0;
        m_sweeps = 0;
        m_done   = 1'b1;
      end
    end
    m_prev_rows = r;
  endfunction

  task automatic tick(input logic ini, input logic [3:0] r, input logic kv, input logic [3:0] k);
    init      = ini;
    rows      = r;
    key_valid = kv;
    key       = k;
    @(negedge clk);
    check("cols", 32'(cols), 32'(exp_cols(r)));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("key_ready", 32'(key_ready), 32'(m_phase == 0));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    if (done) n_done++;
    if (err) n_err++;
    if ((r == 4'b1000) && (cols == 4'b0100)) n_k0_hit++;
    @(posedge clk);
    model_edge(ini, r, kv, k);
    #1;
  endtask

  task automatic run_sweep(input int ncyc, input int kv_at, input logic [3:0] k,
                           input int kv2_at, input logic [3:0] k2, input int init_at);
    logic [3:0] r;
    for (int c = 0; c < ncyc; c++) begin
      r = 4'(1 << ((c / 4) % 4));
      if (c == kv2_at) tick(c == init_at, r, 1'b1, k2);
      else             tick(c == init_at, r, c == kv_at, k);
    end
  endtask

  initial begin
    int         sw_idx;
    int         sw_left;
    logic [3:0] r;
    logic       kv;
    logic [3:0] k;

    init      = 1'b1;
    rows      = 4'b0000;
    key_valid = 1'b0;
    key       = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    run_sweep(32, -1, 4'd0, -1, 4'd0, -1);

    n_done = 0;
    run_sweep(128, 0, 4'd5, -1, 4'd0, -1);
    check("done_pulses_key5", 32'(n_done), 32'd1);

    n_done   = 0;
    n_k0_hit = 0;
    run_sweep(128, 0, 4'd0, 5, 4'd9, -1);
    check("done_pulses_key0", 32'(n_done), 32'd1);
    check("key0_press_cycles", 32'(n_k0_hit), 32'(4 * HOLD_SCANS));

    n_err = 0;
    run_sweep(16, 2, 4'd12, -1, 4'd0, -1);
    check("err_pulses_key12", 32'(n_err), 32'd1);

    n_done = 0;
    run_sweep(80, 0, 4'd1, -1, 4'd0, 20);
    check("done_after_abort", 32'(n_done), 32'd0);

    run_sweep(12, 0, 4'd3, -1, 4'd0, -1);

    sw_idx  = 0;
    sw_left = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        r = 4'($urandom_range(0, 15));
      end else begin
        r = 4'(1 << sw_idx);
        sw_left--;
        if (sw_left == 0) begin
          sw_idx  = (sw_idx + 1) % 4;
          sw_left = $urandom_range(1, 4);
        end
      end
      kv = ($urandom_range(0, 7) == 0);
      k  = 4'($urandom_range(0, 11));
      tick($urandom_range(0, 399) == 0, r, kv, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
